// File: rtl/clk_reset_gen.sv
// Multi-channel tick/square-wave divider with a debounced, sequenced system reset.
// Power-on and a manual pushbutton both drive sys_reset through a hold of HOLD_TICKS pacing ticks.
module clk_reset_gen #(
  parameter int unsigned NUM_TICKS  = 2,
  parameter int unsigned CTR_W      = 17,
  parameter logic [NUM_TICKS*CTR_W-1:0] DIVS = {17'd12000, 17'd120000},
  parameter int unsigned SEQ_CH     = 0,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 manual,
  output logic [NUM_TICKS-1:0] tick,
  output logic [NUM_TICKS-1:0] sq,
  output logic                 sys_reset,
  output logic                 ready
);

  localparam int unsigned HC_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_TICKS - 1);

  // Parameter sanity; a zero field means the divisor was omitted or overflowed its CTR_W slot.
  if (NUM_TICKS < 1) begin : g_bad_num
    $error("clk_reset_gen: NUM_TICKS must be >= 1");
  end
  if (SEQ_CH >= NUM_TICKS) begin : g_bad_seq
    $error("clk_reset_gen: SEQ_CH out of range");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("clk_reset_gen: HOLD_TICKS must be >= 1");
  end

  for (genvar i = 0; i < NUM_TICKS; i++) begin : g_div
    localparam logic [CTR_W-1:0] DIV      = DIVS[i*CTR_W +: CTR_W];
    localparam logic [CTR_W-1:0] DIV_LAST = DIV - 1'b1;

    if (DIV == '0) begin : g_bad_div
      $error("clk_reset_gen: divisor must be >= 1 and fit in CTR_W bits");
    end

    logic [CTR_W-1:0] cnt;
    logic             hit;
    logic             sq_q;

    assign hit     = (cnt == DIV_LAST);
    // Gated so tick reads 0 while rst is held, even for a divide-by-1 channel.
    assign tick[i] = hit & ~rst;
    assign sq[i]   = sq_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt  <= '0;
        sq_q <= 1'b0;
      end else begin
        cnt  <= hit ? '0 : cnt + 1'b1;
        sq_q <= sq_q ^ hit;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous pushbutton.
  logic m_meta;
  logic msync;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_meta <= 1'b0;
      msync  <= 1'b0;
    end else begin
      m_meta <= manual;
      msync  <= m_meta;
    end
  end

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_MANUAL = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic            sys_reset_d, ready_d;
  logic            seq_tick;

  assign seq_tick = tick[SEQ_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_START;
      hold_q    <= '0;
      sys_reset <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      sys_reset <= sys_reset_d;
      ready     <= ready_d;
    end
  end

  // Next state; msync overrides pacing ticks so any bounce restarts the hold.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (msync) begin
      state_d = ST_MANUAL;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        ST_START: begin
          if (seq_tick) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end
        ST_HOLD: begin
          if (seq_tick) begin
            if (hold_q == HOLD_LAST) state_d = ST_RUN;
            else                     hold_d  = hold_q + 1'b1;
          end
        end
        ST_RUN: ;
        ST_MANUAL: begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
        default: begin
          state_d = ST_START;
          hold_d  = '0;
        end
      endcase
    end
    sys_reset_d = (state_d == ST_HOLD) || (state_d == ST_MANUAL);
    ready_d     = (state_d == ST_RUN);
  end

endmodule

// File: tb/tb_clk_reset_gen.sv
// Bench for clk_reset_gen: two configurations (DIV1=4 and DIV1=1) driven with the same
// directed and random rst/manual stimulus, checked against an arithmetic reference model.
module tb_clk_reset_gen;

  localparam int unsigned HOLD = 3;
  localparam int unsigned D0   = 10;
  localparam int unsigned D1A  = 4;
  localparam int unsigned D1B  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       manual;
  logic [1:0] tick_a, sq_a, tick_b, sq_b;
  logic       sys_a, ready_a, sys_b, ready_b;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycles since rst release, manual delay line, hold progress.
  int t;
  bit m1, ms;
  bit started, in_man;
  int hticks;

  always #5 clk = ~clk;

  clk_reset_gen #(
    .NUM_TICKS(2), .CTR_W(8), .DIVS({8'd4, 8'd10}), .SEQ_CH(0), .HOLD_TICKS(HOLD)
  ) dut_a (
    .clk(clk), .rst(rst), .manual(manual),
    .tick(tick_a), .sq(sq_a), .sys_reset(sys_a), .ready(ready_a)
  );

  clk_reset_gen #(
    .NUM_TICKS(2), .CTR_W(8), .DIVS({8'd1, 8'd10}), .SEQ_CH(0), .HOLD_TICKS(HOLD)
  ) dut_b (
    .clk(clk), .rst(rst), .manual(manual),
    .tick(tick_b), .sq(sq_b), .sys_reset(sys_b), .ready(ready_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic bit tk(input int unsigned div);
    return !rst && (((t + 1) % div) == 0);
  endfunction

  function automatic bit sqv(input int unsigned div);
    return ((t / div) % 2) == 1;
  endfunction

  task automatic check_all();
    bit exp_sys, exp_rdy;
    exp_sys = in_man || (started && hticks < HOLD);
    exp_rdy = !in_man && started && hticks >= HOLD;
    chk("tick_a", 32'(tick_a), 32'({tk(D1A), tk(D0)}));
    chk("sq_a",   32'(sq_a),   32'({sqv(D1A), sqv(D0)}));
    chk("sys_a",  32'(sys_a),  32'(exp_sys));
    chk("rdy_a",  32'(ready_a), 32'(exp_rdy));
    chk("tick_b", 32'(tick_b), 32'({tk(D1B), tk(D0)}));
    chk("sq_b",   32'(sq_b),   32'({sqv(D1B), sqv(D0)}));
    chk("sys_b",  32'(sys_b),  32'(exp_sys));
    chk("rdy_b",  32'(ready_b), 32'(exp_rdy));
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic model_edge();
    bit seq;
    if (rst) begin
      t = 0; m1 = 0; ms = 0; started = 0; in_man = 0; hticks = 0;
    end else begin
      seq = ((t + 1) % D0) == 0;
      if (ms) begin
        in_man = 1; started = 1; hticks = 0;
      end else if (in_man) begin
        in_man = 0; hticks = 0;
      end else if (!started) begin
        if (seq) begin started = 1; hticks = 0; end
      end else if (seq && hticks < HOLD) begin
        hticks++;
      end
      ms = m1;
      m1 = manual;
      t++;
    end
  endtask

  task automatic step(input bit r, input bit m);
    @(negedge clk);
    rst    = r;
    manual = m;
    #1;
    check_all();
    model_edge();
  endtask

  task automatic steps(input int n, input bit r, input bit m);
    for (int k = 0; k < n; k++) step(r, m);
  endtask

  initial begin
    rst = 1'b1; manual = 1'b0;
    t = 0; m1 = 0; ms = 0; started = 0; in_man = 0; hticks = 0;
    repeat (2) @(posedge clk);
    steps(2, 1'b1, 1'b0);

    // Power-on sequence and dividers
    step(0, 0);
    chk("plan_tick_b_c0", 32'(tick_b), 32'h2);
    step(0, 0);
    chk("plan_sq_b_c1", 32'(sq_b), 32'h2);
    steps(8, 0, 0);
    chk("plan_tick_a_c9", 32'(tick_a), 32'h1);
    chk("plan_sys_c9", 32'(sys_a), 32'h0);
    steps(30, 0, 0);
    chk("plan_sys_c39", 32'(sys_a), 32'h1);
    step(0, 0);
    chk("plan_rdy_c40", 32'(ready_a), 32'h1);
    chk("plan_sys_c40", 32'(sys_a), 32'h0);
    steps(59, 0, 0);

    // Manual pulse in RUN, cycles 100..119
    steps(3, 0, 1);
    chk("plan_rdy_c102", 32'(ready_a), 32'h1);
    step(0, 1);
    chk("plan_sys_c103", 32'(sys_a), 32'h1);
    chk("plan_rdy_c103", 32'(ready_a), 32'h0);
    steps(16, 0, 1);
    steps(12, 0, 0);

    // Bounce during HOLD at cycles 132..133
    steps(2, 0, 1);
    steps(2, 0, 0);
    chk("plan_sys_c135", 32'(sys_a), 32'h1);
    steps(24, 0, 0);
    chk("plan_rdy_c159", 32'(ready_a), 32'h0);
    step(0, 0);
    chk("plan_rdy_c160", 32'(ready_a), 32'h1);
    steps(10, 0, 0);

    // rst pulse mid-HOLD, then power-on timeline again
    step(1, 0);
    steps(25, 0, 0);
    chk("plan_sys_c24", 32'(sys_a), 32'h1);
    step(1, 0);
    step(0, 0);
    chk("plan_zero_sys", 32'(sys_a), 32'h0);
    chk("plan_zero_sq",  32'(sq_a),  32'h0);
    chk("plan_zero_tick", 32'(tick_a), 32'h0);
    steps(40, 0, 0);
    chk("plan_rdy_rerun", 32'(ready_a), 32'h1);

    // Random manual pulses and bounces with occasional rst
    for (int k = 0; k < 24; k++) begin
      steps(int'($urandom_range(1, 60)), 0, 0);
      steps(int'($urandom_range(1, 25)), 0, 1);
      if ($urandom_range(0, 7) == 0) step(1, 0);
    end
    steps(60, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
